seq_gen_ctrl: RTL and testbench

Run controller for the 4-bit load/shift sequence generator in the FSM lab datapath.
- On start: pulses the generator's load, captures the initial output, then advances the generator for a programmed number of steps.
- Reports the final output, and the sequence period if it is detected within the run.
- Sits between the lab top-level (switches/buttons) and the generator; owns the generator's ld and clock-enable.

---
 rtl/seq_gen_ctrl.sv | 116 +++++++++++
 tb/tb_seq_gen_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_ctrl.sv
// Run controller for the 4-bit load/shift sequence generator: loads it, captures the
// initial word, advances it n_steps times, then reports the final word and detected period.
module seq_gen_ctrl #(
  parameter int CNT_W = 8,
  parameter int Y_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_steps,
  input  logic [Y_W-1:0]   y_in,
  output logic             gen_ld,
  output logic             gen_en,
  output logic             busy,
  output logic             done,
  output logic [Y_W-1:0]   first_y,
  output logic [Y_W-1:0]   y_last,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [2:0]       dbg_state
);

  // Handshake: start is accepted only on an edge where busy=0 (IDLE); it is never queued.
  // Each accepted start yields exactly one done pulse unless abort or reset cancels the run.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CAPT = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] step_cnt;
  logic             run_more;

  // Compare before incrementing so n_lat = all-ones never wraps the counter.
  assign run_more  = (step_cnt < n_lat);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gen_ld    = 1'b0;
    gen_en    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        gen_ld    = 1'b1;
        state_nxt = abort ? IDLE : CAPT;
      end
      CAPT: begin
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        gen_en = run_more;
        if (abort)          state_nxt = IDLE;
        else if (!run_more) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_lat        <= '0;
      step_cnt     <= '0;
      first_y      <= '0;
      y_last       <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        n_lat        <= n_steps;
        step_cnt     <= '0;
        period       <= '0;
        period_valid <= 1'b0;
      end
      if (state == CAPT && !abort) begin
        first_y <= y_in;
      end
      // In RUN, y_in already reflects step_cnt advances of the generator.
      if (state == RUN && !abort) begin
        if (run_more) step_cnt <= step_cnt + 1'b1;
        if (step_cnt != '0 && !period_valid && y_in == first_y) begin
          period       <= step_cnt;
          period_valid <= 1'b1;
        end
        if (!run_more) y_last <= y_in;
      end
    end
  end

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Bench for seq_gen_ctrl: a modulo-counter generator stands in for the lab datapath and
// each run is checked against an arithmetic model of the sequence (final word, period).
module tb_seq_gen_ctrl;
  localparam int CNT_W = 8;
  localparam int Y_W   = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_steps;
  logic [Y_W-1:0]   y_in;
  logic             gen_ld;
  logic             gen_en;
  logic             busy;
  logic             done;
  logic [Y_W-1:0]   first_y;
  logic [Y_W-1:0]   y_last;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  int gen_mod  = 5;
  int gen_load = 0;
  logic [Y_W-1:0] exp_q[$];

  seq_gen_ctrl #(.CNT_W(CNT_W), .Y_W(Y_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_steps(n_steps),
    .y_in(y_in), .gen_ld(gen_ld), .gen_en(gen_en), .busy(busy), .done(done),
    .first_y(first_y), .y_last(y_last), .period(period),
    .period_valid(period_valid), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Generator stand-in: loads gen_load, counts modulo gen_mod on each enabled edge.
  always @(posedge clk or negedge rst) begin
    if (!rst)        y_in <= '0;
    else if (gen_ld) y_in <= Y_W'(gen_load);
    else if (gen_en) y_in <= Y_W'((int'(y_in) + 1) % gen_mod);
  end

  // ---------------- reference model ----------------
  // After k advances the word is (load + k) mod m; the period is the first k >= 1 that
  // returns to the loaded word, if that happens within n advances.
  function automatic void ref_run(input int load, input int m, input int n,
                                  output int exp_last, output int exp_per, output int exp_pv);
    exp_last = (load + n) % m;
    exp_per  = 0;
    exp_pv   = 0;
    for (int k = 1; k <= n; k++) begin
      if (exp_pv == 0 && ((load + k) % m) == load) begin
        exp_per = k;
        exp_pv  = 1;
      end
    end
  endfunction

  // ---------------- driver ----------------
  // Cycle 1 is the cycle right after the edge that samples start.
  task automatic drive_run(input int n, input int abort_at, input bit noisy, input bit abort_with_start,
                           output int ld_cnt, output int ld_cyc, output int en_cnt,
                           output int done_cnt, output int done_cyc, output int busy_gap,
                           output int post_busy);
    ld_cnt = 0; ld_cyc = -1; en_cnt = 0; done_cnt = 0; done_cyc = -1; busy_gap = 0; post_busy = -1;
    @(negedge clk);
    start   = 1'b1;
    abort   = abort_with_start;
    n_steps = CNT_W'(n);
    @(posedge clk);
    for (int c = 1; c <= n + 8; c++) begin
      @(negedge clk);
      if (gen_ld) begin ld_cnt++; ld_cyc = c; end
      if (gen_en) en_cnt++;
      if (!busy) busy_gap++;
      if (done) begin done_cnt++; done_cyc = c; end
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) n_steps = CNT_W'($urandom);
      abort = (abort_at > 0 && c == abort_at + 2);
      if (done) begin start = 1'b0; break; end
      if (abort_at > 0 && c == abort_at + 2) break;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) post_busy = busy;
      start = 1'b0;
      abort = 1'b0;
      if (gen_ld) ld_cnt++;
      if (gen_en) en_cnt++;
      if (done) done_cnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; n_steps = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({gen_ld, gen_en, busy, done} !== 4'b0000) begin n_fails++;
      $display("FAIL reset_strobes got %b want 0000", {gen_ld, gen_en, busy, done}); end
    n_checks++; if ({first_y, y_last} !== '0) begin n_fails++;
      $display("FAIL reset_words got %h/%h want 0/0", first_y, y_last); end
    n_checks++; if ({period, period_valid} !== '0) begin n_fails++;
      $display("FAIL reset_period got %0d/%0d want 0/0", period, period_valid); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fails++;
      $display("FAIL reset_state got %0d want 0", dbg_state); end
  endtask

  task automatic test_run(input string name, input int load, input int m, input int n,
                          input bit noisy, input bit abort_with_start);
    int ld_cnt, ld_cyc, en_cnt, done_cnt, done_cyc, busy_gap, post_busy;
    int exp_last, exp_per, exp_pv;
    gen_load = load;
    gen_mod  = m;
    ref_run(load, m, n, exp_last, exp_per, exp_pv);
    exp_q.push_back(Y_W'(exp_last));
    drive_run(n, 0, noisy, abort_with_start, ld_cnt, ld_cyc, en_cnt, done_cnt, done_cyc, busy_gap, post_busy);
    n_checks++; if (ld_cnt !== 1 || ld_cyc !== 1) begin n_fails++;
      $display("FAIL %s.ld got cnt %0d cyc %0d want 1/1", name, ld_cnt, ld_cyc); end
    n_checks++; if (en_cnt !== n) begin n_fails++;
      $display("FAIL %s.en_cnt got %0d want %0d", name, en_cnt, n); end
    n_checks++; if (done_cnt !== 1) begin n_fails++;
      $display("FAIL %s.done_cnt got %0d want 1", name, done_cnt); end
    n_checks++; if (done_cyc !== n + 4) begin n_fails++;
      $display("FAIL %s.done_cyc got %0d want %0d", name, done_cyc, n + 4); end
    n_checks++; if (busy_gap !== 0 || post_busy !== 0) begin n_fails++;
      $display("FAIL %s.busy got gap %0d post %0d want 0/0", name, busy_gap, post_busy); end
    n_checks++; if (first_y !== Y_W'(load)) begin n_fails++;
      $display("FAIL %s.first_y got %0d want %0d", name, first_y, load); end
    n_checks++; if (y_last !== exp_q.pop_front()) begin n_fails++;
      $display("FAIL %s.y_last got %0d want %0d", name, y_last, exp_last); end
    n_checks++; if (period !== CNT_W'(exp_per) || period_valid !== 1'(exp_pv)) begin n_fails++;
      $display("FAIL %s.period got %0d/%0d want %0d/%0d", name, period, period_valid, exp_per, exp_pv); end
  endtask

  task automatic test_abort();
    int ld_cnt, ld_cyc, en_cnt, done_cnt, done_cyc, busy_gap, post_busy;
    logic [Y_W-1:0] prev_last;
    gen_load = 0;
    gen_mod  = 5;
    prev_last = y_last;
    drive_run(12, 4, 1'b0, 1'b0, ld_cnt, ld_cyc, en_cnt, done_cnt, done_cyc, busy_gap, post_busy);
    n_checks++; if (en_cnt !== 4) begin n_fails++;
      $display("FAIL abort.en_cnt got %0d want 4", en_cnt); end
    n_checks++; if (done_cnt !== 0) begin n_fails++;
      $display("FAIL abort.done_cnt got %0d want 0", done_cnt); end
    n_checks++; if (post_busy !== 0 || ld_cnt !== 1) begin n_fails++;
      $display("FAIL abort.busy_ld got busy %0d ld %0d want 0/1", post_busy, ld_cnt); end
    n_checks++; if (y_last !== prev_last) begin n_fails++;
      $display("FAIL abort.y_last got %0d want %0d", y_last, prev_last); end
    n_checks++; if (period_valid !== 1'b0) begin n_fails++;
      $display("FAIL abort.period_valid got %0d want 0", period_valid); end
    test_run("abort_next", 0, 5, 5, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      int m;
      int load;
      m    = $urandom_range(1, 12);
      load = $urandom_range(0, m - 1);
      test_run($sformatf("rand%0d", r), load, m, $urandom_range(0, 30), 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_midrun();
    int done_seen;
    int busy_seen;
    gen_load = 0;
    gen_mod  = 5;
    done_seen = 0;
    busy_seen = 0;
    @(negedge clk);
    start = 1'b1;
    n_steps = 8'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (gen_en !== 1'b1) begin n_fails++;
      $display("FAIL midrun.gen_en_before got %0d want 1", gen_en); end
    rst = 1'b0;
    #1;
    n_checks++; if ({gen_en, gen_ld, busy, done} !== 4'b0000) begin n_fails++;
      $display("FAIL midrun.strobes got %b want 0000", {gen_en, gen_ld, busy, done}); end
    n_checks++; if (dbg_state !== 3'd0 || first_y !== '0 || period_valid !== 1'b0) begin n_fails++;
      $display("FAIL midrun.regs got state %0d first_y %0d pv %0d want 0/0/0", dbg_state, first_y, period_valid); end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    n_checks++; if (done_seen !== 0 || busy_seen !== 0) begin n_fails++;
      $display("FAIL midrun.after got done %0d busy %0d want 0/0", done_seen, busy_seen); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_run("mod5_n12", 0, 5, 12, 1'b0, 1'b0);
    test_run("mod5_n3", 0, 5, 3, 1'b0, 1'b0);
    test_abort();
    test_run("n0", 0, 5, 0, 1'b0, 1'b0);
    test_run("back_to_back", 0, 5, 9, 1'b1, 1'b0);
    test_run("max_steps", 0, 7, 255, 1'b0, 1'b0);
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
